// File: rtl/seg_execute_muldiv_ctrl_if.sv
// ---------------------------------------------------------------------------
// seg_execute_muldiv_ctrl_if
//   Command/result bundle between the EX stage and the mul/div sequencer.
//   master : EX side (drives command, reads busy/done/HI/LO)
//   slave  : sequencer side
//   i_start/i_op/i_data_a/i_data_b : command and forwarded rs/rt operands
//   i_flush                        : abort in-flight op, suppress same-cycle start
//   o_busy/o_done/o_div0           : stall, completion pulse, divide-by-zero pulse
//   o_hi/o_lo                      : architectural HI/LO registers
// ---------------------------------------------------------------------------
interface seg_execute_muldiv_ctrl_if #(
    parameter int LEN   = 32,
    parameter int NB_OP = 3
);
    logic             i_start;
    logic [NB_OP-1:0] i_op;
    logic [LEN-1:0]   i_data_a;
    logic [LEN-1:0]   i_data_b;
    logic             i_flush;
    logic             o_busy;
    logic             o_done;
    logic [LEN-1:0]   o_hi;
    logic [LEN-1:0]   o_lo;
    logic             o_div0;

    modport master (
        output i_start, i_op, i_data_a, i_data_b, i_flush,
        input  o_busy, o_done, o_hi, o_lo, o_div0
    );

    modport slave (
        input  i_start, i_op, i_data_a, i_data_b, i_flush,
        output o_busy, o_done, o_hi, o_lo, o_div0
    );
endinterface

// File: rtl/seg_execute_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// seg_execute_muldiv_ctrl
//   Iterative multiply/divide sequencer beside the EX stage. Runs a shift-add
//   multiply or restoring divide over LEN cycles (IDLE -> RUN -> FIX), owns
//   HI/LO and raises o_busy as a pipeline stall while an op is in flight.
//   Ports:
//     i_clk, i_rst : clock, synchronous active-high reset
//     bus (slave)  : command in, busy/done/div0/HI/LO out
//   Optional macro MDU_DIV0_DETECT_EN: divide by zero short-cuts straight to
//   FIX (HI=dividend, LO=all ones) and pulses o_div0 with o_done. Without it
//   a zero divisor runs the normal iteration and o_div0 is tied low.
// ---------------------------------------------------------------------------
module seg_execute_muldiv_ctrl #(
    parameter int LEN    = 32,
    parameter int NB_OP  = 3,
    parameter int NB_CNT = 6
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    seg_execute_muldiv_ctrl_if.slave bus
);
    localparam logic [NB_OP-1:0] OP_MULT  = NB_OP'(1);
    localparam logic [NB_OP-1:0] OP_MULTU = NB_OP'(2);
    localparam logic [NB_OP-1:0] OP_DIV   = NB_OP'(3);
    localparam logic [NB_OP-1:0] OP_DIVU  = NB_OP'(4);
    localparam logic [NB_OP-1:0] OP_MTHI  = NB_OP'(5);
    localparam logic [NB_OP-1:0] OP_MTLO  = NB_OP'(6);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t            state;
    logic [NB_CNT-1:0] cnt;
    logic [2*LEN-1:0]  acc;     // mult: {partial, multiplier}; div: {rem, quot}
    logic [LEN-1:0]    opnd;    // multiplicand or divisor magnitude
    logic              is_div;
    logic              neg_p;   // negate product / quotient
    logic              neg_r;   // negate remainder
    logic              busy, done, div0;
    logic [LEN-1:0]    hi, lo;
`ifdef MDU_DIV0_DETECT_EN
    logic              div0_pend;
`endif

    // operand magnitudes for the incoming command
    logic           is_sgn, is_mul_op, is_div_op;
    logic [LEN-1:0] mag_a, mag_b;
    always_comb begin
        is_mul_op = (bus.i_op == OP_MULT) || (bus.i_op == OP_MULTU);
        is_div_op = (bus.i_op == OP_DIV)  || (bus.i_op == OP_DIVU);
        is_sgn    = (bus.i_op == OP_MULT) || (bus.i_op == OP_DIV);
        mag_a     = (is_sgn && bus.i_data_a[LEN-1]) ? -bus.i_data_a : bus.i_data_a;
        mag_b     = (is_sgn && bus.i_data_b[LEN-1]) ? -bus.i_data_b : bus.i_data_b;
    end

    // one iteration step of each algorithm, plus sign fix-up of the result
    logic [LEN:0]     mul_sum;
    logic [2*LEN:0]   div_sh;
    logic [LEN:0]     div_diff;
    logic [2*LEN-1:0] step_nxt;
    logic [2*LEN-1:0] prod_fix;
    logic [LEN-1:0]   fix_hi, fix_lo;
    always_comb begin
        mul_sum  = {1'b0, acc[2*LEN-1:LEN]} + (acc[0] ? {1'b0, opnd} : '0);
        div_sh   = {acc, 1'b0};
        div_diff = div_sh[2*LEN:LEN] - {1'b0, opnd};
        if (!is_div)
            step_nxt = {mul_sum, acc[LEN-1:1]};
        else if (!div_diff[LEN])   // trial subtraction fits: keep it, quotient bit 1
            step_nxt = {div_diff[LEN-1:0], div_sh[LEN-1:1], 1'b1};
        else
            step_nxt = div_sh[2*LEN-1:0];

        prod_fix = neg_p ? -acc : acc;
        if (is_div) begin
            fix_hi = neg_r ? -acc[2*LEN-1:LEN] : acc[2*LEN-1:LEN];
            fix_lo = neg_p ? -acc[LEN-1:0]     : acc[LEN-1:0];
        end else begin
            fix_hi = prod_fix[2*LEN-1:LEN];
            fix_lo = prod_fix[LEN-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_p  <= 1'b0;
            neg_r  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            div0   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
`ifdef MDU_DIV0_DETECT_EN
            div0_pend <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            div0 <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_start && !bus.i_flush) begin
                        if (is_mul_op || is_div_op) begin
                            cnt    <= '0;
                            is_div <= is_div_op;
                            neg_p  <= is_sgn && (bus.i_data_a[LEN-1] ^ bus.i_data_b[LEN-1]);
                            neg_r  <= is_sgn && bus.i_data_a[LEN-1];
                            acc    <= is_div_op ? {{LEN{1'b0}}, mag_a} : {{LEN{1'b0}}, mag_b};
                            opnd   <= is_div_op ? mag_b : mag_a;
                            busy   <= 1'b1;
                            state  <= RUN;
`ifdef MDU_DIV0_DETECT_EN
                            div0_pend <= 1'b0;
                            if (is_div_op && (bus.i_data_b == '0)) begin
                                // unsigned view of the raw dividend, no sign fix-up
                                acc       <= {bus.i_data_a, {LEN{1'b1}}};
                                neg_p     <= 1'b0;
                                neg_r     <= 1'b0;
                                div0_pend <= 1'b1;
                                state     <= FIX;
                            end
`endif
                        end else if (bus.i_op == OP_MTHI) begin
                            hi <= bus.i_data_a;
                        end else if (bus.i_op == OP_MTLO) begin
                            lo <= bus.i_data_a;
                        end
                    end
                end
                RUN: begin
                    if (bus.i_flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        acc <= step_nxt;
                        cnt <= cnt + 1'b1;
                        if (cnt == NB_CNT'(LEN-1))
                            state <= FIX;
                    end
                end
                FIX: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (!bus.i_flush) begin
                        hi   <= fix_hi;
                        lo   <= fix_lo;
                        done <= 1'b1;
`ifdef MDU_DIV0_DETECT_EN
                        div0 <= div0_pend;
`endif
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy = busy;
    assign bus.o_done = done;
    assign bus.o_div0 = div0;
    assign bus.o_hi   = hi;
    assign bus.o_lo   = lo;
endmodule

// File: doc/seg_execute_muldiv_ctrl.md
Name: seg_execute_muldiv_ctrl

Overview:
Iterative multiply/divide sequencer attached beside the EX stage of the 5-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from EX and runs a shift-add multiply or a restoring divide over LEN cycles. It holds the architectural HI/LO registers and raises a stall toward hazard control while it is busy. Flush from branch/hazard logic aborts an in-flight operation.

Parameters:
LEN, 32, operand/HI/LO width
NB_OP, 3, command code width
NB_CNT, 6, iteration counter width (must satisfy 2^NB_CNT > LEN)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_start  in  1  command valid from EX (qualified with i_op)
i_op  in  NB_OP  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 none
i_data_a  in  LEN  rs operand (forwarded value); dividend / multiplicand / MTHI-MTLO source
i_data_b  in  LEN  rt operand (forwarded value); divisor / multiplier
i_flush  in  1  abort in-flight op; suppress same-cycle start
o_busy  out  1  registered; high while the op is in RUN or FIX; drives pipeline stall
o_done  out  1  one-cycle pulse when HI/LO receive a MUL/DIV result
o_hi  out  LEN  HI register
o_lo  out  LEN  LO register
o_div0  out  1  one-cycle pulse when a divide by zero completes (see Optional Feature)

Behaviour:
- Reset (i_clk edge with i_rst=1): state IDLE, HI=0, LO=0, counter=0, o_busy=0, o_done=0, o_div0=0. Reset overrides every other input. Reset mid-operation discards the op, and HI/LO become 0.
- States: IDLE, RUN, FIX.
- IDLE: i_start=1, i_flush=0, op in {MULT, MULTU, DIV, DIVU} → latch magnitudes (signed ops take abs of the operands), record result signs, counter=0 → RUN.
  - MTHI/MTLO: write i_data_a to HI/LO at this edge. Stay in IDLE; no busy, no done.
  - op none: no effect.
- RUN: one partial step per cycle, counter++.
  - Multiply: 2*LEN-bit shift-add product.
  - Divide: restoring quotient/remainder.
  - After LEN steps (counter==LEN-1) → FIX.
- FIX: apply signs.
  - Signed mult: negate the 2*LEN product if the operand signs differ.
  - Signed div: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Load HI=upper/remainder and LO=lower/quotient. Pulse o_done next cycle → IDLE.
- Timing: start accepted at edge T. o_busy=1 for cycles T+1..T+LEN+1 (LEN+1 cycles). HI/LO new value and o_done=1 in cycle T+LEN+2, with o_busy=0 in that same cycle.
- Signed DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps, no trap).
- i_start while busy: ignored (EX is stalled and re-presents the command; the controller must not re-latch).
- i_flush while in RUN/FIX: → IDLE next edge. HI/LO unchanged, no o_done, o_busy=0 next cycle.
- i_flush with i_start in IDLE: no op accepted, including MTHI/MTLO.
- HI/LO read by EX (MFHI/MFLO) directly from o_hi/o_lo. Hazard control stalls MFHI/MFLO while o_busy=1.
- All arithmetic is modulo 2^LEN per register. Unsigned ops take no sign handling.

Optional Feature:
Macro MDU_DIV0_DETECT_EN.
- Defined: a DIV/DIVU with i_data_b==0 accepted at T skips RUN and goes straight to FIX.
  - o_busy=1 only in cycle T+1.
  - HI=i_data_a (as latched) and LO=0xFFFFFFFF.
  - o_done and o_div0 both pulse in cycle T+2.
- Undefined: divide by zero runs the full LEN+2 latency. HI/LO are updated with implementation-defined values, o_done pulses normally, and o_div0 is tied 0.

Test Plan:
1. MULTU a=0xFFFFFFFF, b=2 at T → o_busy high T+1..T+33; at T+34 o_done=1, HI=0x00000001, LO=0xFFFFFFFE.
2. MULT a=0xFFFFFFFD (-3), b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV a=0xFFFFFFF9 (-7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. DIVU a=100, b=7 → LO=14, HI=2 at T+34. Then MTHI a=0x1234 in IDLE → HI=0x1234 next cycle, o_busy stays 0, no o_done.
4. HI=0xAA, LO=0xBB; start MULTU, assert i_flush at T+10 → o_busy=0 at T+11, state IDLE, HI/LO stay 0xAA/0xBB, no o_done through T+40. Also: start+flush in the same cycle → nothing accepted.
5. Start DIV while o_busy=1 with different operands → ignored; result reflects the original operands only. Assert i_rst at T+5 → next cycle o_busy=0, HI=LO=0.
6. With MDU_DIV0_DETECT_EN: DIVU a=5, b=0 → o_busy only at T+1; at T+2 o_done=o_div0=1, HI=5, LO=0xFFFFFFFF. Without the macro: o_done at T+34, o_div0 stays 0.
